// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous_fifo write port among NUM_REQ requesters,
// with bursts of up to MAX_BURST writes per grant. Optional stats: define FIFO_ARB_STATS_EN.

`ifdef FIFO_ARB_STATS_EN
module fifo_wr_arbiter_satcnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule
`endif

module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            accept,
    input  logic                          full,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         data_in
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]         stat_acc,
    output logic [15:0]                   stat_stall
`endif
);
    localparam int            IW      = $clog2(NUM_REQ);
    localparam logic [7:0]    BLAST   = 8'(MAX_BURST - 1);
    localparam logic [IW-1:0] LASTIDX = IW'(NUM_REQ - 1);

    typedef enum logic {IDLE, OWN} state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          own_q, own_d;
    logic [IW-1:0]          rr_q, rr_d;
    logic [7:0]             bcnt_q, bcnt_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;

    logic [IW-1:0]          own_inc, scan_start, win_idx;
    logic                   win_vld, own_acc, rel;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rd_lane;

    assign rd_lane = req_data;
    assign gnt     = gnt_q;
    assign accept  = gnt_q & req & {NUM_REQ{~full}};
    assign w_en    = |accept;
    assign data_in = (state_q == OWN) ? rd_lane[own_q] : '0;

    assign own_inc    = (own_q == LASTIDX) ? '0 : own_q + IW'(1);
    assign own_acc    = accept[own_q];
    assign rel        = (state_q == OWN) && (!req[own_q] || (own_acc && bcnt_q == BLAST));
    // While owning, the scan only matters on release, and then it starts after the owner.
    assign scan_start = (state_q == OWN) ? own_inc : rr_q;

    always_comb begin
        int            j;
        logic [IW-1:0] jj;
        win_vld = 1'b0;
        win_idx = '0;
        j       = 0;
        jj      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(scan_start) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            jj = IW'(j);
            if (!win_vld && req[jj]) begin
                win_vld = 1'b1;
                win_idx = jj;
            end
        end
    end

    always_comb begin
        logic rearb;
        state_d = state_q;
        own_d   = own_q;
        rr_d    = rr_q;
        bcnt_d  = bcnt_q;
        gnt_d   = gnt_q;
        rearb   = 1'b0;
        case (state_q)
            IDLE: rearb = 1'b1;
            OWN: begin
                if (rel) begin
                    rr_d  = own_inc;
                    rearb = 1'b1;
                end else if (own_acc) begin
                    bcnt_d = bcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rearb) begin
            bcnt_d = '0;
            if (win_vld) begin
                state_d = OWN;
                own_d   = win_idx;
                gnt_d   = NUM_REQ'(1) << win_idx;
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            own_q   <= '0;
            rr_q    <= '0;
            bcnt_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            rr_q    <= rr_d;
            bcnt_q  <= bcnt_d;
            gnt_q   <= gnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic stall;
    assign stall = (state_q == OWN) && req[own_q] && full;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_acc
        fifo_wr_arbiter_satcnt u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc_i (accept[i]),
            .cnt_o (stat_acc[i*16 +: 16])
        );
    end

    fifo_wr_arbiter_satcnt u_stall (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall),
        .cnt_o (stat_stall)
    );
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences, random vs. reference model.
// Instance A: 5 requesters (non-power-of-two wrap), MAX_BURST 4. Instance B: 4 requesters, MAX_BURST 2.

module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  reqA, gnA, acA;
    logic [39:0] rdA;
    logic        fullA, weA;
    logic [7:0]  diA;
    logic [3:0]  reqB, gnB, acB;
    logic [31:0] rdB;
    logic        fullB, weB;
    logic [7:0]  diB;
`ifdef FIFO_ARB_STATS_EN
    logic [79:0] saA;
    logic [15:0] ssA;
    logic [63:0] saB;
    logic [15:0] ssB;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(5), .MAX_BURST(4)) dA (
        .clk(clk), .rst(rst), .req(reqA), .req_data(rdA), .gnt(gnA), .accept(acA),
        .full(fullA), .w_en(weA), .data_in(diA)
`ifdef FIFO_ARB_STATS_EN
        , .stat_acc(saA), .stat_stall(ssA)
`endif
    );

    fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(2)) dB (
        .clk(clk), .rst(rst), .req(reqB), .req_data(rdB), .gnt(gnB), .accept(acB),
        .full(fullB), .w_en(weB), .data_in(diB)
`ifdef FIFO_ARB_STATS_EN
        , .stat_acc(saB), .stat_stall(ssB)
`endif
    );

    typedef struct {
        logic [4:0] req;
        logic       full;
        logic [4:0] gnt;
        logic [4:0] acc;
        logic       wen;
        logic [7:0] data;
    } vec_t;

    // Reference model: owner index (-1 idle), writes in current burst, round-robin start.
    typedef struct {
        int own;
        int cnt;
        int rr;
    } mstate_t;

    function automatic mstate_t mstep(mstate_t s, logic [7:0] r, logic f, int n, int mb);
        mstate_t t = s;
        int start = -1;
        if (s.own < 0) begin
            start = s.rr;
        end else begin
            bit acc = r[s.own] && !f;
            if (!r[s.own] || (acc && s.cnt == mb - 1)) begin
                t.rr  = (s.own + 1) % n;
                start = t.rr;
            end else if (acc) begin
                t.cnt = s.cnt + 1;
            end
        end
        if (start >= 0) begin
            t.own = -1;
            t.cnt = 0;
            for (int k = 0; k < n; k++)
                if (t.own < 0 && r[(start + k) % n]) t.own = (start + k) % n;
        end
        return t;
    endfunction

    // Packed {data_in, w_en, accept, gnt} expected from model state.
    function automatic logic [24:0] mexp(mstate_t s, logic [7:0] r, logic f, logic [63:0] rd);
        logic [7:0] g, a, d;
        g = (s.own < 0) ? 8'h00 : (8'h01 << s.own);
        a = g & r & {8{!f}};
        d = (s.own < 0) ? 8'h00 : rd[s.own*8 +: 8];
        return {d, |a, a, g};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst   = 1'b1;
        reqA  = '0;
        reqB  = '0;
        fullA = 1'b0;
        fullB = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    vec_t    tbl[16];
    mstate_t mA, mB;

    initial begin
        tbl[0]  = '{5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 8'h00};
        tbl[1]  = '{5'b00100, 1'b0, 5'b00000, 5'b00000, 1'b0, 8'h00};
        tbl[2]  = '{5'b00100, 1'b0, 5'b00100, 5'b00100, 1'b1, 8'hA2};
        tbl[3]  = '{5'b00100, 1'b0, 5'b00100, 5'b00100, 1'b1, 8'hA2};
        tbl[4]  = '{5'b00100, 1'b1, 5'b00100, 5'b00000, 1'b0, 8'hA2};
        tbl[5]  = '{5'b00100, 1'b0, 5'b00100, 5'b00100, 1'b1, 8'hA2};
        tbl[6]  = '{5'b00110, 1'b0, 5'b00100, 5'b00100, 1'b1, 8'hA2};
        tbl[7]  = '{5'b00110, 1'b0, 5'b00010, 5'b00010, 1'b1, 8'hA1};
        tbl[8]  = '{5'b00100, 1'b0, 5'b00010, 5'b00000, 1'b0, 8'hA1};
        tbl[9]  = '{5'b00000, 1'b0, 5'b00100, 5'b00000, 1'b0, 8'hA2};
        tbl[10] = '{5'b10001, 1'b0, 5'b00000, 5'b00000, 1'b0, 8'h00};
        tbl[11] = '{5'b10001, 1'b0, 5'b10000, 5'b10000, 1'b1, 8'hA4};
        tbl[12] = '{5'b00001, 1'b0, 5'b10000, 5'b00000, 1'b0, 8'hA4};
        tbl[13] = '{5'b00001, 1'b0, 5'b00001, 5'b00001, 1'b1, 8'hA0};
        tbl[14] = '{5'b00000, 1'b0, 5'b00001, 5'b00000, 1'b0, 8'hA0};
        tbl[15] = '{5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 8'h00};

        reqA = '1; reqB = '1; fullA = 1'b0; fullB = 1'b0;
        rdA = 40'hA4A3A2A1A0; rdB = 32'hB3B2B1B0;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_gnt", gnA, 5'b0);
        chk("rst_acc", acA, 5'b0);
        chk("rst_wen", weA, 1'b0);
        chk("rst_data", diA, 8'h00);
        chk("rst_rr", dA.rr_q, 0);
        chk("rst_bcnt", dA.bcnt_q, 0);
        do_reset();

        // Vector table on instance A
        for (int i = 0; i < 16; i++) begin
            reqA  = tbl[i].req;
            fullA = tbl[i].full;
            #1;
            chk($sformatf("tbl%0d_gnt", i), gnA, tbl[i].gnt);
            chk($sformatf("tbl%0d_acc", i), acA, tbl[i].acc);
            chk($sformatf("tbl%0d_wen", i), weA, tbl[i].wen);
            chk($sformatf("tbl%0d_data", i), diA, tbl[i].data);
            tick();
        end

        // Single requester: ten words with self re-grant across burst boundaries
        do_reset();
        rdA  = 40'h0;
        reqA = 5'b00100;
        #1 chk("single_grant_lat", gnA, 5'b0);
        tick();
        for (int c = 0; c < 10; c++) begin
            rdA[23:16] = 8'h10 + 8'(c);
            #1;
            chk($sformatf("single%0d_gnt", c), gnA, 5'b00100);
            chk($sformatf("single%0d_wen", c), weA, 1'b1);
            chk($sformatf("single%0d_data", c), diA, 8'h10 + 8'(c));
            tick();
        end
        reqA = '0;

        // All requesters on B, two accepts per owner, no idle cycles
        do_reset();
        reqB = 4'hF;
        #1 chk("all_grant_lat", gnB, 4'b0);
        tick();
        for (int k = 0; k < 16; k++) begin
            #1;
            chk($sformatf("all%0d_gnt", k), gnB, 4'b0001 << ((k / 2) % 4));
            chk($sformatf("all%0d_wen", k), weB, 1'b1);
            tick();
        end
        reqB = '0;

        // Full backpressure mid-burst
        do_reset();
        reqA = 5'b00001;
        tick();
        #1 chk("bp_first_wen", weA, 1'b1);
        tick();
        chk("bp_bcnt_pre", dA.bcnt_q, 1);
        fullA = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp%0d_wen", k), weA, 1'b0);
            chk($sformatf("bp%0d_acc", k), acA, 5'b0);
            chk($sformatf("bp%0d_gnt", k), gnA, 5'b00001);
            tick();
            chk($sformatf("bp%0d_bcnt", k), dA.bcnt_q, 1);
        end
        fullA = 1'b0;
        #1;
        chk("bp_resume_wen", weA, 1'b1);
        chk("bp_resume_acc", acA, 5'b00001);
        tick();
        reqA = '0;

        // Early release: owner 1 drops after one write, requester 3 waiting
        do_reset();
        reqA = 5'b00010;
        tick();
        #1 chk("er_gnt1", gnA, 5'b00010);
        tick();
        reqA = 5'b01000;
        #1 chk("er_drop_wen", weA, 1'b0);
        tick();
        chk("er_gnt3", gnA, 5'b01000);
        chk("er_rr", dA.rr_q, 2);
        reqA = '0;

        // Reset mid-burst, then arbitration restarts from index 0
        do_reset();
        reqA = 5'b01000;
        tick();
        reqA = 5'b00001;
        tick();
        tick();
        tick();
        chk("rmb_bcnt", dA.bcnt_q, 2);
        chk("rmb_gnt_pre", gnA, 5'b00001);
        #1 rst = 1'b1;
        #1;
        chk("rmb_gnt", gnA, 5'b0);
        chk("rmb_wen", weA, 1'b0);
        chk("rmb_data", diA, 8'h00);
        #2 rst = 1'b0;
        #1 reqA = 5'b10010;
        tick();
        chk("rmb_restart_gnt", gnA, 5'b00010);
        reqA = '0;

        // Randomized run against the reference model on both instances
        do_reset();
        mA = '{-1, 0, 0};
        mB = '{-1, 0, 0};
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic [31:0] r;
            r     = $urandom;
            reqA  = r[4:0] | r[9:5];
            reqB  = r[13:10] | r[17:14];
            fullA = ($urandom_range(0, 3) == 0);
            fullB = ($urandom_range(0, 4) == 0);
            rdA   = {$urandom, $urandom};
            rdB   = $urandom;
            #1;
            chk($sformatf("randA_c%0d", cyc), {diA, weA, 3'b0, acA, 3'b0, gnA},
                mexp(mA, {3'b0, reqA}, fullA, {24'b0, rdA}));
            chk($sformatf("randB_c%0d", cyc), {diB, weB, 4'b0, acB, 4'b0, gnB},
                mexp(mB, {4'b0, reqB}, fullB, {32'b0, rdB}));
            mA = mstep(mA, {3'b0, reqA}, fullA, 5, 4);
            mB = mstep(mB, {4'b0, reqB}, fullB, 4, 2);
            tick();
        end

`ifdef FIFO_ARB_STATS_EN
        do_reset();
        reqA = 5'b00001;
        for (int c = 0; c < 70010; c++) begin
            fullA = (c >= 100 && c < 107);
            tick();
        end
        fullA = 1'b0;
        reqA  = '0;
        chk("stat_acc0_sat", saA[15:0], 16'hFFFF);
        chk("stat_acc_others", saA[79:16], 64'h0);
        chk("stat_stall", ssA, 16'd7);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
